suprloco_video_core: RTL and testbench

- Top-level emulation board core for the Super Locomotive video path, clocked by the 40 MHz emulation master clock.
- Derives a pixel clock-enable and raster timing, then drives a 3-3-3 RGB stream with a video-enable flag.
- The board's screen-capture model consumes this stream: it samples RGB on master-clock edges where CEN is high and EN is high.
- Scope is fixed to timing plus a deterministic raster test pattern. It provides a bring-up picture for display and capture alignment until game video logic is attached.

---
 rtl/suprloco_video_pkg.sv | 30 +++
 rtl/suprloco_video_timing.sv | 53 +++++
 rtl/suprloco_video_core.sv | 58 +++++
 tb/tb_suprloco_video_core.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/suprloco_video_pkg.sv
// Shared timing constants, counter widths and pixel type for the Super Locomotive video path.
package suprloco_video_pkg;

    localparam int unsigned CEN_DIV  = 8;
    localparam int unsigned H_TOTAL  = 320;
    localparam int unsigned H_ACTIVE = 256;
    localparam int unsigned V_TOTAL  = 262;
    localparam int unsigned V_ACTIVE = 224;

    localparam int unsigned DIV_W   = 3;
    localparam int unsigned H_W     = 9;
    localparam int unsigned V_W     = 9;
    localparam int unsigned FRAME_W = 8;

    typedef struct packed {
        logic [2:0] r;
        logic [2:0] g;
        logic [2:0] b;
    } rgb333_t;

    localparam rgb333_t RGB_WHITE = '{r: 3'd7, g: 3'd7, b: 3'd7};

    // Interior bring-up pattern: coarse horizontal/vertical bands, blue tracks the frame count.
    function automatic rgb333_t test_pattern(input logic [H_W-1:0]     h,
                                             input logic [V_W-1:0]     v,
                                             input logic [FRAME_W-1:0] frame);
        test_pattern = '{r: h[7:5], g: v[7:5], b: frame[2:0]};
    endfunction

endpackage

// File: rtl/suprloco_video_timing.sv
// Pixel clock-enable divider plus horizontal, vertical and frame counters.
module suprloco_video_timing
    import suprloco_video_pkg::*;
#(
    parameter int unsigned CEN_DIV  = suprloco_video_pkg::CEN_DIV,
    parameter int unsigned H_TOTAL  = suprloco_video_pkg::H_TOTAL,
    parameter int unsigned H_ACTIVE = suprloco_video_pkg::H_ACTIVE,
    parameter int unsigned V_TOTAL  = suprloco_video_pkg::V_TOTAL,
    parameter int unsigned V_ACTIVE = suprloco_video_pkg::V_ACTIVE
) (
    input  logic               clk,
    input  logic               rst,
    output logic               cen,
    output logic [H_W-1:0]     h,
    output logic [V_W-1:0]     v,
    output logic [FRAME_W-1:0] frame,
    output logic               active
);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CEN_DIV - 1);
    localparam logic [H_W-1:0]   H_LAST   = H_W'(H_TOTAL - 1);
    localparam logic [V_W-1:0]   V_LAST   = V_W'(V_TOTAL - 1);

    logic [DIV_W-1:0] div;

    assign cen    = (div == DIV_LAST) && !rst;
    assign active = (h < H_W'(H_ACTIVE)) && (v < V_W'(V_ACTIVE));

    always_ff @(posedge clk) begin
        if (rst) begin
            div   <= '0;
            h     <= '0;
            v     <= '0;
            frame <= '0;
        end else begin
            div <= (div == DIV_LAST) ? '0 : div + 1'b1;
            if (cen) begin
                if (h == H_LAST) begin
                    h <= '0;
                    if (v == V_LAST) begin
                        v     <= '0;
                        frame <= frame + 1'b1;
                    end else begin
                        v <= v + 1'b1;
                    end
                end else begin
                    h <= h + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/suprloco_video_core.sv
// Super Locomotive video core: raster timing driving a bordered 3-3-3 RGB test pattern.
module suprloco_video_core
    import suprloco_video_pkg::*;
#(
    parameter int unsigned CEN_DIV  = suprloco_video_pkg::CEN_DIV,
    parameter int unsigned H_TOTAL  = suprloco_video_pkg::H_TOTAL,
    parameter int unsigned H_ACTIVE = suprloco_video_pkg::H_ACTIVE,
    parameter int unsigned V_TOTAL  = suprloco_video_pkg::V_TOTAL,
    parameter int unsigned V_ACTIVE = suprloco_video_pkg::V_ACTIVE
) (
    input  logic       i_EMU_CLK40M,
    input  logic       i_EMU_RST,
    output logic       o_VIDEO_CEN,
    output logic       o_VIDEO_EN,
    output logic [2:0] o_VIDEO_R,
    output logic [2:0] o_VIDEO_G,
    output logic [2:0] o_VIDEO_B
);

    logic               active;
    logic [H_W-1:0]     h;
    logic [V_W-1:0]     v;
    logic [FRAME_W-1:0] frame;
    logic               border;
    rgb333_t            pix;

    suprloco_video_timing #(
        .CEN_DIV (CEN_DIV),
        .H_TOTAL (H_TOTAL),
        .H_ACTIVE(H_ACTIVE),
        .V_TOTAL (V_TOTAL),
        .V_ACTIVE(V_ACTIVE)
    ) u_timing (
        .clk   (i_EMU_CLK40M),
        .rst   (i_EMU_RST),
        .cen   (o_VIDEO_CEN),
        .h     (h),
        .v     (v),
        .frame (frame),
        .active(active)
    );

    // Reset gates the outputs combinationally so they drop in the same cycle it rises.
    always_comb begin
        pix    = '0;
        border = (h == '0) || (h == H_W'(H_ACTIVE - 1)) ||
                 (v == '0) || (v == V_W'(V_ACTIVE - 1));
        if (active && !i_EMU_RST) begin
            pix = border ? RGB_WHITE : test_pattern(h, v, frame);
        end
    end

    assign o_VIDEO_EN = active && !i_EMU_RST;
    assign o_VIDEO_R  = pix.r;
    assign o_VIDEO_G  = pix.g;
    assign o_VIDEO_B  = pix.b;

endmodule

// File: tb/tb_suprloco_video_core.sv
// Scoreboard bench: full-size core plus a reduced-geometry core for frame-level behaviour.
module tb_suprloco_video_core;

    typedef struct packed {
        logic       cen;
        logic       en;
        logic [2:0] r;
        logic [2:0] g;
        logic [2:0] b;
    } pix_t;

    // Reduced geometry keeps frame wrap and vertical blanking within a short run.
    localparam int unsigned SD = 8, SHT = 80, SHA = 64, SVT = 40, SVA = 36;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cen_b, en_b, cen_s, en_s;
    logic [2:0] r_b, g_b, b_b, r_s, g_s, b_s;

    int unsigned total = 0, bad = 0, n = 0;
    int unsigned en_cnt_b = 0, blank_cnt_b = 0, en_cnt_s = 0;
    pix_t q_b[$];
    pix_t q_s[$];

    always #5 clk = ~clk;

    suprloco_video_core dut (
        .i_EMU_CLK40M(clk), .i_EMU_RST(rst), .o_VIDEO_CEN(cen_b), .o_VIDEO_EN(en_b),
        .o_VIDEO_R(r_b), .o_VIDEO_G(g_b), .o_VIDEO_B(b_b)
    );

    suprloco_video_core #(
        .CEN_DIV(SD), .H_TOTAL(SHT), .H_ACTIVE(SHA), .V_TOTAL(SVT), .V_ACTIVE(SVA)
    ) dut_sm (
        .i_EMU_CLK40M(clk), .i_EMU_RST(rst), .o_VIDEO_CEN(cen_s), .o_VIDEO_EN(en_s),
        .o_VIDEO_R(r_s), .o_VIDEO_G(g_s), .o_VIDEO_B(b_s)
    );

    // Expected output after cyc clock edges since reset release, derived arithmetically.
    function automatic pix_t model(input int unsigned cyc, input int unsigned d,
                                   input int unsigned ht, input int unsigned ha,
                                   input int unsigned vt, input int unsigned va);
        int unsigned p, h, v, fr;
        pix_t e;
        p  = cyc / d;
        h  = p % ht;
        v  = (p / ht) % vt;
        fr = (p / (ht * vt)) % 256;
        e  = '0;
        e.cen = ((cyc % d) == d - 1);
        if (h < ha && v < va) begin
            e.en = 1'b1;
            if (h == 0 || h == ha - 1 || v == 0 || v == va - 1) begin
                e.r = 3'd7; e.g = 3'd7; e.b = 3'd7;
            end else begin
                e.r = 3'((h >> 5) & 7);
                e.g = 3'((v >> 5) & 7);
                e.b = 3'(fr & 7);
            end
        end
        return e;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h n=%0d t=%0t", tag, got, exp, n, $time);
        end
    endtask

    task automatic score(input bit sm, input pix_t got);
        pix_t e, q;
        if (rst) begin
            check_val(sm ? "rst_out_s" : "rst_out_b", 32'(got), 32'd0);
        end else begin
            e = sm ? model(n, SD, SHT, SHA, SVT, SVA) : model(n, 8, 320, 256, 262, 224);
            check_val(sm ? "cen_s" : "cen_b", 32'(got.cen), 32'(e.cen));
            if (e.cen) begin
                if (sm) q_s.push_back(e); else q_b.push_back(e);
            end
            if (got.cen) begin
                if ((sm ? q_s.size() : q_b.size()) == 0) begin
                    check_val(sm ? "sb_empty_s" : "sb_empty_b", 32'(got.cen), 32'd0);
                end else begin
                    q = sm ? q_s.pop_front() : q_b.pop_front();
                    check_val(sm ? "pix_s" : "pix_b", 32'(got[9:0]), 32'(q[9:0]));
                end
                if (sm) begin
                    if (got.en) en_cnt_s++;
                end else begin
                    if (got.en) en_cnt_b++; else blank_cnt_b++;
                end
            end
        end
    endtask

    task automatic observe();
        score(1'b0, {cen_b, en_b, r_b, g_b, b_b});
        score(1'b1, {cen_s, en_s, r_s, g_s, b_s});
    endtask

    task automatic step();
        @(posedge clk);
        if (rst) n = 0; else n++;
        @(negedge clk);
        observe();
    endtask

    task automatic goto(input int unsigned tgt);
        int unsigned guard = 0;
        while (n < tgt && guard < 200000) begin
            step();
            guard++;
        end
        check_val("goto", n, tgt);
    endtask

    task automatic wait_first_cen(input string tag);
        int unsigned k = 1;
        while (!cen_b && k < 16) begin
            step();
            k++;
        end
        check_val(tag, k, 8);
        check_val({tag, "_s"}, 32'(cen_s), 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        repeat (10) step();
        rst = 1'b0;
        #1 observe();
        en_cnt_b = 0; blank_cnt_b = 0; en_cnt_s = 0;

        wait_first_cen("first_cen");
        check_val("first_pix_b", 32'({en_b, r_b, g_b, b_b}), 32'h3FF);
        check_val("first_pix_s", 32'({en_s, r_s, g_s, b_s}), 32'h3FF);

        goto(2559);
        check_val("line0_en_b", en_cnt_b, 256);
        check_val("line0_blank_b", blank_cnt_b, 64);
        en_cnt_b = 0; blank_cnt_b = 0;

        goto(3367);
        check_val("interior_b", 32'({en_b, r_b, g_b, b_b}), 32'(10'b1_011_000_000));

        goto(5119);
        check_val("line1_en_b", en_cnt_b, 256);
        check_val("line1_blank_b", blank_cnt_b, 64);

        goto(25599);
        check_val("frame_en_s", en_cnt_s, SHA * SVA);

        goto(25607);
        check_val("wrap_cen_s", 32'(cen_s), 32'd1);
        check_val("wrap_pix_s", 32'({en_s, r_s, g_s, b_s}), 32'h3FF);

        goto(32087);
        check_val("frame1_int_s", 32'({en_s, r_s, g_s, b_s}), 32'(10'b1_000_000_001));

        goto(38500);
        rst = 1'b1;
        #1;
        check_val("rst_now_b", 32'({cen_b, en_b, r_b, g_b, b_b}), 32'd0);
        check_val("rst_now_s", 32'({cen_s, en_s, r_s, g_s, b_s}), 32'd0);
        repeat (3) step();
        rst = 1'b0;
        #1 observe();

        wait_first_cen("restart_cen");
        check_val("restart_pix_s", 32'({en_s, r_s, g_s, b_s}), 32'h3FF);
        goto(6487);
        check_val("restart_int_s", 32'({en_s, r_s, g_s, b_s}), 32'(10'b1_000_000_000));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
